// File: rtl/shifter_pkg.sv
// Shared types and helpers for the pipelined barrel shifter.
// Covers the operation encoding and the pipeline depth calculation.
package shifter_pkg;

    typedef enum logic [1:0] {
        SHIFT_SLL = 2'b00,
        SHIFT_SRL = 2'b01,
        SHIFT_SRA = 2'b10,
        SHIFT_ROR = 2'b11
    } shift_op_t;

    // Number of pipeline registers: one per group of reg_every stages, rounded up.
    function automatic int calc_lat(input int shamt_w, input int reg_every);
        return (shamt_w + reg_every - 1) / reg_every;
    endfunction

endpackage

// File: rtl/pipelined_barrel_shifter_if.sv
// Operand/result handshake bundle for the pipelined barrel shifter.
// The master side feeds operands and consumes results; the slave side is the shifter.
interface pipelined_barrel_shifter_if import shifter_pkg::*; #(
    parameter int WIDTH = 32
);
    localparam int SHAMT_W = $clog2(WIDTH);

    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_data;
    logic [SHAMT_W-1:0] in_shamt;
    shift_op_t          in_op;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_data;
    logic               out_zero;

    modport master (
        output in_valid, in_data, in_shamt, in_op, out_ready,
        input  in_ready, out_valid, out_data, out_zero
    );

    modport slave (
        input  in_valid, in_data, in_shamt, in_op, out_ready,
        output in_ready, out_valid, out_data, out_zero
    );

endinterface

// File: rtl/pipelined_barrel_shifter_stage.sv
// One combinational power-of-two shift step of the barrel shifter.
// Shifts or rotates by DIST when enabled, otherwise passes the data through.
module shift_stage import shifter_pkg::*; #(
    parameter int WIDTH = 32,
    parameter int DIST  = 1
) (
    input  logic [WIDTH-1:0] data,
    input  logic             enable,
    input  shift_op_t        op,
    output logic [WIDTH-1:0] shifted
);

    always_comb begin
        shifted = data;
        if (enable) begin
            case (op)
                SHIFT_SLL: shifted = {data[WIDTH-DIST-1:0], {DIST{1'b0}}};
                SHIFT_SRL: shifted = {{DIST{1'b0}}, data[WIDTH-1:DIST]};
                // Every earlier SRA step keeps the MSB, so it still holds the original sign.
                SHIFT_SRA: shifted = {{DIST{data[WIDTH-1]}}, data[WIDTH-1:DIST]};
                SHIFT_ROR: shifted = {data[DIST-1:0], data[WIDTH-1:DIST]};
                default:   shifted = data;
            endcase
        end
    end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter: log2(WIDTH) shift stages, largest distance first,
// a register after every REG_EVERY stages, and a whole-pipeline stall on backpressure.
module pipelined_barrel_shifter import shifter_pkg::*; #(
    parameter int WIDTH     = 32,
    parameter int REG_EVERY = 1
) (
    input logic                      clock,
    input logic                      reset,
    pipelined_barrel_shifter_if.slave bus
);

    localparam int SHAMT_W = $clog2(WIDTH);
    localparam int LAT     = calc_lat(SHAMT_W, REG_EVERY);

    logic               advance;

    logic [WIDTH-1:0]   stg_in    [SHAMT_W];
    logic [WIDTH-1:0]   stg_out   [SHAMT_W];
    logic [SHAMT_W-1:0] stg_shamt [SHAMT_W];
    shift_op_t          stg_op    [SHAMT_W];

    logic               vld_d     [LAT];
    logic [WIDTH-1:0]   data_d    [LAT];
    logic [SHAMT_W-1:0] shamt_d   [LAT];
    shift_op_t          op_d      [LAT];

    logic               vld_p     [LAT];
    logic [WIDTH-1:0]   data_p    [LAT];
    logic [SHAMT_W-1:0] shamt_p   [LAT];
    shift_op_t          op_p      [LAT];
    logic               zero_p;

    assign advance       = !vld_p[LAT-1] || bus.out_ready;
    assign bus.in_ready  = advance;
    assign bus.out_valid = vld_p[LAT-1];
    assign bus.out_data  = data_p[LAT-1];
    assign bus.out_zero  = zero_p;

    // Stage j shifts by 2^(SHAMT_W-1-j); the first stage of each group reads the previous register.
    for (genvar j = 0; j < SHAMT_W; j++) begin : g_stage
        localparam int K = SHAMT_W - 1 - j;
        localparam int G = j / REG_EVERY;

        if (j == 0) begin : g_src_in
            assign stg_in[j] = bus.in_data;
        end else if (j % REG_EVERY == 0) begin : g_src_reg
            assign stg_in[j] = data_p[G-1];
        end else begin : g_src_comb
            assign stg_in[j] = stg_out[j-1];
        end

        if (G == 0) begin : g_ctl_in
            assign stg_shamt[j] = bus.in_shamt;
            assign stg_op[j]    = bus.in_op;
        end else begin : g_ctl_reg
            assign stg_shamt[j] = shamt_p[G-1];
            assign stg_op[j]    = op_p[G-1];
        end

        shift_stage #(
            .WIDTH (WIDTH),
            .DIST  (1 << K)
        ) u_stage (
            .data    (stg_in[j]),
            .enable  (stg_shamt[j][K]),
            .op      (stg_op[j]),
            .shifted (stg_out[j])
        );
    end

    // Register g captures the last stage of group g; the final group may be short.
    for (genvar g = 0; g < LAT; g++) begin : g_reg_in
        localparam int LAST_J = ((g + 1) * REG_EVERY < SHAMT_W) ? (g + 1) * REG_EVERY - 1
                                                                 : SHAMT_W - 1;
        assign data_d[g] = stg_out[LAST_J];

        if (g == 0) begin : g_head
            assign vld_d[g]   = bus.in_valid;
            assign shamt_d[g] = bus.in_shamt;
            assign op_d[g]    = bus.in_op;
        end else begin : g_body
            assign vld_d[g]   = vld_p[g-1];
            assign shamt_d[g] = shamt_p[g-1];
            assign op_d[g]    = op_p[g-1];
        end
    end

    // Pipeline registers p0..p(LAT-1); payload only loads with a valid beat so the
    // output keeps its last result after draining.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int g = 0; g < LAT; g++) begin
                vld_p[g]   <= 1'b0;
                data_p[g]  <= '0;
                shamt_p[g] <= '0;
                op_p[g]    <= SHIFT_SLL;
            end
            zero_p <= 1'b0;
        end else if (advance) begin
            for (int g = 0; g < LAT; g++) begin
                vld_p[g] <= vld_d[g];
                if (vld_d[g]) begin
                    data_p[g]  <= data_d[g];
                    shamt_p[g] <= shamt_d[g];
                    op_p[g]    <= op_d[g];
                end
            end
            if (vld_d[LAT-1]) begin
                zero_p <= (data_d[LAT-1] == '0);
            end
        end
    end

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Directed and randomised bench for pipelined_barrel_shifter: a 32-bit default
// instance (LAT=5) and a 16-bit instance with two stages per register (LAT=2).
module tb_pipelined_barrel_shifter;
    import shifter_pkg::*;

    logic clock = 1'b0;
    logic rst_a;
    logic rst_b;
    always #5 clock = ~clock;

    pipelined_barrel_shifter_if #(.WIDTH(32)) bus_a ();
    pipelined_barrel_shifter_if #(.WIDTH(16)) bus_b ();

    pipelined_barrel_shifter #(.WIDTH(32), .REG_EVERY(1)) dut_a (
        .clock (clock),
        .reset (rst_a),
        .bus   (bus_a)
    );

    pipelined_barrel_shifter #(.WIDTH(16), .REG_EVERY(2)) dut_b (
        .clock (clock),
        .reset (rst_b),
        .bus   (bus_b)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  shamt;
        shift_op_t   op;
        logic [31:0] exp_data;
        logic        exp_zero;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Independent reference: shifts on a 64-bit copy masked to w bits.
    function automatic logic [31:0] ref_shift(input logic [31:0] d, input int s,
                                              input logic [1:0] op, input int w);
        logic [63:0] m;
        logic [63:0] x;
        logic [63:0] r;
        m = (64'd1 << w) - 64'd1;
        x = {32'd0, d} & m;
        case (op)
            2'b00:   r = (x << s) & m;
            2'b01:   r = x >> s;
            2'b10: begin
                r = x >> s;
                if (x[w-1]) r = r | (m & ~(m >> s));
            end
            default: r = ((x >> s) | (x << (w - s))) & m;
        endcase
        return r[31:0];
    endfunction

    // Single transaction on the 32-bit instance; checks latency, data and zero flag.
    task automatic run_a(input string name, input logic [31:0] d, input logic [4:0] s,
                         input shift_op_t op, input logic [31:0] exp, input logic expz);
        int n;
        bus_a.out_ready = 1'b1;
        bus_a.in_valid  = 1'b1;
        bus_a.in_data   = d;
        bus_a.in_shamt  = s;
        bus_a.in_op     = op;
        #1;
        check({name, " in_ready"}, 32'(bus_a.in_ready), 32'd1);
        tick();
        bus_a.in_valid = 1'b0;
        bus_a.in_data  = 32'hDEAD_BEEF;
        n = 0;
        while (!bus_a.out_valid && n < 20) begin
            tick();
            n++;
        end
        check({name, " latency"}, 32'(n), 32'd4);
        check({name, " data"}, bus_a.out_data, exp);
        check({name, " zero"}, 32'(bus_a.out_zero), 32'(expz));
        tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int got;
        int sent;
        int first;
        int last;
        int n;
        int accepted;
        logic [31:0] q [$];
        logic [31:0] e;
        logic [31:0] rnd;
        logic [3:0]  s4;
        logic [1:0]  op2;
        logic        iv;
        logic        ordy;
        logic        hold_chk;
        logic [15:0] hold_val;

        vecs[0]  = '{32'h8000_00F0, 5'd16, SHIFT_SRA, 32'hFFFF_8000, 1'b0};
        vecs[1]  = '{32'h0000_0001, 5'd1,  SHIFT_ROR, 32'h8000_0000, 1'b0};
        vecs[2]  = '{32'h0000_00FF, 5'd8,  SHIFT_SRL, 32'h0000_0000, 1'b1};
        vecs[3]  = '{32'hA5A5_0F0F, 5'd0,  SHIFT_SLL, 32'hA5A5_0F0F, 1'b0};
        vecs[4]  = '{32'hA5A5_0F0F, 5'd0,  SHIFT_SRL, 32'hA5A5_0F0F, 1'b0};
        vecs[5]  = '{32'hA5A5_0F0F, 5'd0,  SHIFT_SRA, 32'hA5A5_0F0F, 1'b0};
        vecs[6]  = '{32'hA5A5_0F0F, 5'd0,  SHIFT_ROR, 32'hA5A5_0F0F, 1'b0};
        vecs[7]  = '{32'h0000_0003, 5'd31, SHIFT_SLL, 32'h8000_0000, 1'b0};
        vecs[8]  = '{32'h8000_0001, 5'd31, SHIFT_SRL, 32'h0000_0001, 1'b0};
        vecs[9]  = '{32'h8000_0000, 5'd31, SHIFT_SRA, 32'hFFFF_FFFF, 1'b0};
        vecs[10] = '{32'h7FFF_FFFF, 5'd31, SHIFT_SRA, 32'h0000_0000, 1'b1};
        vecs[11] = '{32'h1234_5678, 5'd4,  SHIFT_ROR, 32'h8123_4567, 1'b0};
        vecs[12] = '{32'h1234_5678, 5'd4,  SHIFT_SLL, 32'h2345_6780, 1'b0};
        vecs[13] = '{32'hF000_0000, 5'd28, SHIFT_SRL, 32'h0000_000F, 1'b0};

        rst_a = 1'b1;
        rst_b = 1'b1;
        bus_a.in_valid = 1'b0; bus_a.in_data = '0; bus_a.in_shamt = '0;
        bus_a.in_op = SHIFT_SLL; bus_a.out_ready = 1'b0;
        bus_b.in_valid = 1'b0; bus_b.in_data = '0; bus_b.in_shamt = '0;
        bus_b.in_op = SHIFT_SLL; bus_b.out_ready = 1'b0;
        #2;
        check("reset out_valid", 32'(bus_a.out_valid), 32'd0);
        check("reset out_data", bus_a.out_data, 32'd0);
        check("reset out_zero", 32'(bus_a.out_zero), 32'd0);
        @(posedge clock);
        #3;
        rst_a = 1'b0;
        rst_b = 1'b0;
        #1;
        check("reset in_ready", 32'(bus_a.in_ready), 32'd1);
        tick();

        for (int i = 0; i < 14; i++) begin
            run_a($sformatf("vec%0d", i), vecs[i].data, vecs[i].shamt, vecs[i].op,
                  vecs[i].exp_data, vecs[i].exp_zero);
        end

        // Back-to-back SLL of 1 by 0..7 with the consumer always ready.
        bus_a.out_ready = 1'b1;
        got = 0; sent = 0; first = -1; last = -1;
        for (int cyc = 0; cyc < 30 && got < 8; cyc++) begin
            if (bus_a.out_valid) begin
                check("b2b data", bus_a.out_data, 32'd1 << got);
                got++;
                if (first < 0) first = cyc;
                last = cyc;
            end
            if (sent < 8) begin
                bus_a.in_valid = 1'b1; bus_a.in_data = 32'd1;
                bus_a.in_shamt = 5'(sent); bus_a.in_op = SHIFT_SLL;
                #1;
                check("b2b in_ready", 32'(bus_a.in_ready), 32'd1);
                sent++;
            end else begin
                bus_a.in_valid = 1'b0;
            end
            tick();
        end
        bus_a.in_valid = 1'b0;
        check("b2b count", 32'(got), 32'd8);
        check("b2b consecutive", 32'(last - first), 32'd7);
        tick();

        // Fill with five transactions behind a stalled consumer.
        bus_a.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus_a.in_valid = 1'b1; bus_a.in_data = 32'hF000_0000;
            bus_a.in_shamt = 5'(i); bus_a.in_op = SHIFT_SRL;
            #1;
            check("stall fill in_ready", 32'(bus_a.in_ready), 32'd1);
            tick();
        end
        bus_a.in_data = 32'h1234_5678; bus_a.in_shamt = 5'd3;
        for (int i = 0; i < 10; i++) begin
            check("stall out_valid", 32'(bus_a.out_valid), 32'd1);
            check("stall out_data", bus_a.out_data, 32'hF000_0000);
            check("stall in_ready", 32'(bus_a.in_ready), 32'd0);
            tick();
        end
        bus_a.in_valid = 1'b0;
        bus_a.out_ready = 1'b1;
        #1;
        got = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (bus_a.out_valid) begin
                check("stall drain data", bus_a.out_data, 32'hF000_0000 >> got);
                got++;
            end
            tick();
        end
        check("stall drain count", 32'(got), 32'd5);
        check("drained out_valid", 32'(bus_a.out_valid), 32'd0);
        check("drained out_data kept", bus_a.out_data, 32'h0F00_0000);

        // Reset with three transactions pending, the oldest held at the output.
        bus_a.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus_a.in_valid = 1'b1; bus_a.in_data = 32'h0000_00FF;
            bus_a.in_shamt = 5'(i + 1); bus_a.in_op = SHIFT_SLL;
            tick();
        end
        bus_a.in_valid = 1'b0;
        n = 0;
        while (!bus_a.out_valid && n < 10) begin
            tick();
            n++;
        end
        check("pre-reset data", bus_a.out_data, 32'h0000_01FE);
        #2;
        rst_a = 1'b1;
        #1;
        check("async reset out_valid", 32'(bus_a.out_valid), 32'd0);
        check("async reset out_data", bus_a.out_data, 32'd0);
        check("async reset out_zero", 32'(bus_a.out_zero), 32'd0);
        tick();
        tick();
        #2;
        rst_a = 1'b0;
        #1;
        check("post-reset in_ready", 32'(bus_a.in_ready), 32'd1);
        bus_a.out_ready = 1'b1;
        n = 0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            if (bus_a.out_valid) n++;
            tick();
        end
        check("no stale results", 32'(n), 32'd0);
        run_a("post-reset txn", 32'h0000_0F00, 5'd8, SHIFT_SRL, 32'h0000_000F, 1'b0);

        // 16-bit instance: one transaction should appear one edge after accept.
        bus_b.out_ready = 1'b1;
        bus_b.in_valid = 1'b1; bus_b.in_data = 16'h8421;
        bus_b.in_shamt = 4'd5; bus_b.in_op = SHIFT_ROR;
        tick();
        bus_b.in_valid = 1'b0;
        n = 0;
        while (!bus_b.out_valid && n < 10) begin
            tick();
            n++;
        end
        check("B latency", 32'(n), 32'd1);
        check("B single data", 32'(bus_b.out_data), ref_shift(32'h8421, 5, 2'b11, 16));
        tick();

        // Random traffic with random backpressure against the reference model.
        accepted = 0;
        hold_chk = 1'b0;
        hold_val = '0;
        for (int cyc = 0; cyc < 8000 && (accepted < 1000 || q.size() > 0); cyc++) begin
            if (hold_chk) begin
                check("B stall hold valid", 32'(bus_b.out_valid), 32'd1);
                check("B stall hold data", 32'(bus_b.out_data), 32'(hold_val));
            end
            iv   = (accepted < 1000) && ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 3) != 0);
            rnd  = $urandom;
            s4   = 4'($urandom_range(0, 15));
            op2  = 2'($urandom_range(0, 3));
            bus_b.in_valid  = iv;
            bus_b.in_data   = rnd[15:0];
            bus_b.in_shamt  = s4;
            bus_b.in_op     = shift_op_t'(op2);
            bus_b.out_ready = ordy;
            #1;
            check("B in_ready", 32'(bus_b.in_ready), 32'(!bus_b.out_valid || ordy));
            if (bus_b.out_valid && ordy) begin
                if (q.size() == 0) begin
                    check("B spurious result", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    check("B data", 32'(bus_b.out_data), e);
                    check("B zero", 32'(bus_b.out_zero), 32'(e == 32'd0));
                end
            end
            hold_chk = bus_b.out_valid && !ordy;
            hold_val = bus_b.out_data;
            if (iv && bus_b.in_ready) begin
                q.push_back(ref_shift({16'd0, rnd[15:0]}, int'(s4), op2, 16));
                accepted++;
            end
            tick();
        end
        bus_b.in_valid = 1'b0;
        check("B accepted", 32'(accepted), 32'd1000);
        check("B scoreboard empty", 32'(q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
